// File: rtl/hilo_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit: op codes, FSM states, defaults.
package hilo_pkg;

    localparam int DEF_WIDTH       = 32;
    localparam int DEF_MUL_LATENCY = 2;

    typedef enum logic [2:0] {
        OP_MULT  = 3'b000,
        OP_MULTU = 3'b001,
        OP_DIV   = 3'b010,
        OP_DIVU  = 3'b011,
        OP_MTHI  = 3'b100,
        OP_MTLO  = 3'b101,
        OP_MADD  = 3'b110,
        OP_MSUB  = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } state_e;

    function automatic logic op_is_signed(input op_e op);
        return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
    endfunction

endpackage

// File: rtl/hilo_muldiv_unit_if.sv
// Request/result bundle between the execute stage and the HI/LO unit.
interface hilo_muldiv_unit_if #(
    parameter int WIDTH = hilo_pkg::DEF_WIDTH
);
    logic             Start;
    logic [2:0]       Op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Flush;
    logic             ReadHi;
    logic             ReadLo;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;
    logic             Busy;
    logic             Done;
    logic             Stall;

    modport master (
        output Start, Op, A, B, Flush, ReadHi, ReadLo,
        input  HI, LO, Busy, Done, Stall
    );

    modport slave (
        input  Start, Op, A, B, Flush, ReadHi, ReadLo,
        output HI, LO, Busy, Done, Stall
    );
endinterface

// File: rtl/hilo_muldiv_unit_div_iter.sv
// Unsigned restoring divider: one quotient bit per clock, WIDTH iterations after start.
module div_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             last,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] quo_reg, rem_reg, dvs_reg;
    logic [WIDTH-1:0] quo_next, rem_next;
    logic [CNT_W-1:0] cnt_reg;
    logic             active_reg;
    logic [WIDTH:0]   shifted;
    logic             borrow;

    // A zero divisor never borrows, so the dividend shifts straight into the remainder.
    always_comb begin
        shifted  = {rem_reg, quo_reg[WIDTH-1]};
        borrow   = (shifted < {1'b0, dvs_reg});
        rem_next = borrow ? shifted[WIDTH-1:0] : (shifted[WIDTH-1:0] - dvs_reg);
        quo_next = {quo_reg[WIDTH-2:0], ~borrow};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quo_reg    <= '0;
            rem_reg    <= '0;
            dvs_reg    <= '0;
            cnt_reg    <= '0;
            active_reg <= 1'b0;
        end else if (start) begin
            quo_reg    <= dividend;
            rem_reg    <= '0;
            dvs_reg    <= divisor;
            cnt_reg    <= CNT_W'(WIDTH);
            active_reg <= 1'b1;
        end else if (abort) begin
            cnt_reg    <= '0;
            active_reg <= 1'b0;
        end else if (active_reg) begin
            if (cnt_reg != '0) begin
                quo_reg <= quo_next;
                rem_reg <= rem_next;
                cnt_reg <= cnt_reg - CNT_W'(1);
            end else begin
                active_reg <= 1'b0;
            end
        end
    end

    assign last      = active_reg && (cnt_reg == CNT_W'(1));
    assign done      = active_reg && (cnt_reg == '0);
    assign quotient  = quo_reg;
    assign remainder = rem_reg;

endmodule

// File: rtl/hilo_muldiv_unit.sv
// HI/LO owner for MULT/MULTU/DIV/DIVU/MTHI/MTLO; define HILO_MADD_EN to add MADD/MSUB.
module hilo_muldiv_unit
    import hilo_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int MUL_LATENCY = DEF_MUL_LATENCY
) (
    input  logic              Clk,
    input  logic              Rst_n,
    hilo_muldiv_unit_if.slave bus
);
    localparam int CNT_W = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;

    state_e             state_reg, state_next;
    op_e                op_reg, op_in;
    logic [WIDTH-1:0]   a_reg, b_reg, hi_reg, lo_reg, hi_next, lo_next;
    logic [CNT_W-1:0]   mul_cnt_reg;
    logic               done_reg, wr_en;
    logic               start_ok, is_mul, is_div;
    logic               in_signed, reg_signed, q_neg, r_neg;
    logic [WIDTH-1:0]   a_mag, b_mag, hi_fix, lo_fix;
    logic [2*WIDTH-1:0] a_ext, b_ext, product, mul_result;
    logic               div_start, div_last, div_done;
    logic [WIDTH-1:0]   div_quo, div_rem;

    assign op_in    = op_e'(bus.Op);
    assign start_ok = bus.Start && !bus.Flush && (state_reg == IDLE);

    always_comb begin
        is_mul = 1'b0;
        is_div = 1'b0;
        case (op_in)
            OP_MULT, OP_MULTU: is_mul = 1'b1;
            OP_DIV, OP_DIVU:   is_div = 1'b1;
`ifdef HILO_MADD_EN
            OP_MADD, OP_MSUB:  is_mul = 1'b1;
`endif
            default: ;
        endcase
    end

    // Divider works on magnitudes; signs are restored in FIX from the latched operands.
    assign in_signed = op_is_signed(op_in);
    assign a_mag     = (in_signed && bus.A[WIDTH-1]) ? -bus.A : bus.A;
    assign b_mag     = (in_signed && bus.B[WIDTH-1]) ? -bus.B : bus.B;
    assign div_start = start_ok && is_div;

    div_iter #(.WIDTH(WIDTH)) u_div_iter (
        .clk       (Clk),
        .rst_n     (Rst_n),
        .start     (div_start),
        .abort     (bus.Flush),
        .dividend  (a_mag),
        .divisor   (b_mag),
        .last      (div_last),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    assign reg_signed = op_is_signed(op_reg);
    assign a_ext      = {{WIDTH{reg_signed & a_reg[WIDTH-1]}}, a_reg};
    assign b_ext      = {{WIDTH{reg_signed & b_reg[WIDTH-1]}}, b_reg};
    assign product    = a_ext * b_ext;

`ifdef HILO_MADD_EN
    always_comb begin
        case (op_reg)
            OP_MADD: mul_result = {hi_reg, lo_reg} + product;
            OP_MSUB: mul_result = {hi_reg, lo_reg} - product;
            default: mul_result = product;
        endcase
    end
`else
    assign mul_result = product;
`endif

    assign q_neg  = reg_signed & (a_reg[WIDTH-1] ^ b_reg[WIDTH-1]);
    assign r_neg  = reg_signed & a_reg[WIDTH-1];
    assign hi_fix = (b_reg == '0) ? a_reg : (r_neg ? -div_rem : div_rem);
    assign lo_fix = (b_reg == '0) ? '1    : (q_neg ? -div_quo : div_quo);

    always_comb begin
        state_next = state_reg;
        wr_en      = 1'b0;
        hi_next    = hi_reg;
        lo_next    = lo_reg;
        case (state_reg)
            IDLE: begin
                if (start_ok) begin
                    if (is_mul) begin
                        state_next = MUL;
                    end else if (is_div) begin
                        state_next = DIV;
                    end else if (op_in == OP_MTHI) begin
                        wr_en   = 1'b1;
                        hi_next = bus.A;
                    end else if (op_in == OP_MTLO) begin
                        wr_en   = 1'b1;
                        lo_next = bus.A;
                    end
                end
            end
            MUL: begin
                if (bus.Flush) begin
                    state_next = IDLE;
                end else if (mul_cnt_reg == '0) begin
                    state_next         = IDLE;
                    wr_en              = 1'b1;
                    {hi_next, lo_next} = mul_result;
                end
            end
            DIV: begin
                if (bus.Flush) begin
                    state_next = IDLE;
                end else if (div_last) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                if (bus.Flush) begin
                    state_next = IDLE;
                end else if (div_done) begin
                    state_next = IDLE;
                    wr_en      = 1'b1;
                    hi_next    = hi_fix;
                    lo_next    = lo_fix;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_reg   <= IDLE;
            op_reg      <= OP_MULT;
            a_reg       <= '0;
            b_reg       <= '0;
            hi_reg      <= '0;
            lo_reg      <= '0;
            mul_cnt_reg <= '0;
            done_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            hi_reg    <= hi_next;
            lo_reg    <= lo_next;
            done_reg  <= wr_en;
            if (start_ok) begin
                op_reg      <= op_in;
                a_reg       <= bus.A;
                b_reg       <= bus.B;
                mul_cnt_reg <= CNT_W'(MUL_LATENCY - 1);
            end else if (state_reg == MUL && mul_cnt_reg != '0) begin
                mul_cnt_reg <= mul_cnt_reg - CNT_W'(1);
            end
        end
    end

    assign bus.HI    = hi_reg;
    assign bus.LO    = lo_reg;
    assign bus.Busy  = (state_reg != IDLE);
    assign bus.Done  = done_reg;
    assign bus.Stall = bus.Busy & (bus.ReadHi | bus.ReadLo | bus.Start);

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed scoreboard bench for hilo_muldiv_unit (WIDTH=32, MUL_LATENCY=2).
module tb_hilo_muldiv_unit;
    import hilo_pkg::*;

    localparam int W   = 32;
    localparam int LAT = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hilo_muldiv_unit_if #(.WIDTH(W)) bus();

    hilo_muldiv_unit #(.WIDTH(W), .MUL_LATENCY(LAT)) dut (
        .Clk   (clk),
        .Rst_n (rst_n),
        .bus   (bus)
    );

    int          tests = 0;
    int          fails = 0;
    logic [63:0] exp_q[$];
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Reference result {HI,LO} computed with wide native arithmetic.
    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, b,
                                          input logic [31:0] hi, lo);
        longint          sa, sb, sq, sr;
        longint unsigned ua, ub;
        logic [31:0]     uq, ur;
        logic [63:0]     acc;
        sa  = $signed(a);
        sb  = $signed(b);
        ua  = a;
        ub  = b;
        acc = {hi, lo};
        case (op)
            3'b000: return sa * sb;
            3'b001: return ua * ub;
            3'b010: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                sq = sa / sb;
                sr = sa % sb;
                return {sr[31:0], sq[31:0]};
            end
            3'b011: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                uq = a / b;
                ur = a % b;
                return {ur, uq};
            end
            3'b100: return {a, lo};
            3'b101: return {hi, a};
            3'b110: return acc + 64'(sa * sb);
            default: return acc - 64'(sa * sb);
        endcase
    endfunction

    task automatic do_op(input logic [2:0] op, input logic [31:0] a, b, input int lat,
                         input string tag);
        logic [63:0] e;
        int          n;
        exp_q.push_back(model(op, a, b, m_hi, m_lo));
        bus.Op    = op;
        bus.A     = a;
        bus.B     = b;
        bus.Start = 1'b1;
        tick();
        bus.Start = 1'b0;
        if (lat > 0) chk({tag, "_busy"}, 64'(bus.Busy), 64'd1);
        n = 0;
        while (!bus.Done && n < 60) begin
            tick();
            n++;
        end
        e = exp_q.pop_front();
        chk({tag, "_latency"}, 64'(n), 64'(lat));
        chk({tag, "_busy_in_done"}, 64'(bus.Busy), 64'd0);
        chk({tag, "_hilo"}, {bus.HI, bus.LO}, e);
        {m_hi, m_lo} = e;
        tick();
        chk({tag, "_done_pulse"}, 64'(bus.Done), 64'd0);
        $display("[TB] %s op=%0d A=%h B=%h -> HI=%h LO=%h after %0d edges",
                 tag, op, a, b, bus.HI, bus.LO, n);
    endtask

    task automatic watch_no_done(input int cycles, input string tag);
        int d = 0;
        int b = 0;
        repeat (cycles) begin
            if (bus.Done) d++;
            if (bus.Busy) b++;
            tick();
        end
        chk({tag, "_no_done"}, 64'(d), 64'd0);
        chk({tag, "_no_busy"}, 64'(b), 64'd0);
        chk({tag, "_hilo_kept"}, {bus.HI, bus.LO}, {m_hi, m_lo});
        $display("[TB] %s: HI=%h LO=%h, no completion over %0d cycles", tag, bus.HI, bus.LO, cycles);
    endtask

    initial begin
        int          n;
        int          stall_cnt;
        logic [1:0]  rop;
        logic [31:0] ra, rb;
        logic [63:0] e;

        bus.Start = 0; bus.Op = '0; bus.A = '0; bus.B = '0;
        bus.Flush = 0; bus.ReadHi = 0; bus.ReadLo = 0;
        repeat (2) tick();
        chk("rst_hilo", {bus.HI, bus.LO}, 64'd0);
        chk("rst_busy", 64'(bus.Busy), 64'd0);
        chk("rst_done", 64'(bus.Done), 64'd0);
        chk("rst_stall", 64'(bus.Stall), 64'd0);
        rst_n = 1'b1;
        tick();
        $display("[TB] reset released");

        do_op(OP_MULT,  32'hFFFF_FFFE, 32'd3, LAT, "mult_neg");
        chk("mult_neg_const", {bus.HI, bus.LO}, 64'hFFFF_FFFF_FFFF_FFFA);
        do_op(OP_MULTU, 32'hFFFF_FFFE, 32'd3, LAT, "multu");
        chk("multu_const", {bus.HI, bus.LO}, 64'h0000_0002_FFFF_FFFA);
        do_op(OP_DIV,   32'hFFFF_FFF9, 32'd2, W + 1, "div_neg");
        chk("div_neg_const", {bus.HI, bus.LO}, 64'hFFFF_FFFF_FFFF_FFFD);
        do_op(OP_DIVU,  32'd100, 32'd0, W + 1, "divu_by0");
        chk("divu_by0_const", {bus.HI, bus.LO}, 64'h0000_0064_FFFF_FFFF);
        do_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, W + 1, "div_ovf");
        do_op(OP_DIV,   32'hFFFF_FF9C, 32'd0, W + 1, "div_by0_signed");
        do_op(OP_DIV,   32'd100, 32'hFFFF_FFF9, W + 1, "div_pos_neg");
        do_op(OP_MTHI,  32'h11, 32'd0, 0, "mthi");
        do_op(OP_MTLO,  32'h22, 32'd0, 0, "mtlo");

        // Flush mid-divide: raised after E7 so the FSM is idle after E8.
        bus.Op = OP_DIV; bus.A = 32'd50; bus.B = 32'd3; bus.Start = 1'b1;
        tick();
        bus.Start = 1'b0;
        repeat (7) tick();
        bus.Flush = 1'b1;
        tick();
        bus.Flush = 1'b0;
        chk("flush_busy", 64'(bus.Busy), 64'd0);
        chk("flush_hilo", {bus.HI, bus.LO}, 64'h0000_0011_0000_0022);
        watch_no_done(40, "flush_div");

        bus.Op = OP_DIV; bus.A = 32'd9; bus.B = 32'd2; bus.Start = 1'b1; bus.Flush = 1'b1;
        tick();
        bus.Start = 1'b0; bus.Flush = 1'b0;
        watch_no_done(40, "flush_with_start");

        // Hazard: a Start at E3 is refused, MFLO from E5 stalls until the result lands.
        exp_q.push_back(model(OP_DIV, 32'd1000, 32'd7, m_hi, m_lo));
        bus.Op = OP_DIV; bus.A = 32'd1000; bus.B = 32'd7; bus.Start = 1'b1;
        tick();
        bus.Start = 1'b0;
        n = 0;
        stall_cnt = 0;
        while (!bus.Done && n < 60) begin
            tick();
            n++;
            bus.Start = 1'b0;
            if (n == 3) begin
                bus.Op = OP_MTHI; bus.A = 32'hDEAD; bus.Start = 1'b1;
            end
            if (n == 5) bus.ReadLo = 1'b1;
            #1;
            if (bus.Stall) stall_cnt++;
            if (n == 3) chk("hz_start_stall", 64'(bus.Stall), 64'd1);
        end
        e = exp_q.pop_front();
        chk("hz_latency", 64'(n), 64'(W + 1));
        chk("hz_stall_cycles", 64'(stall_cnt), 64'd29);
        chk("hz_stall_done", 64'(bus.Stall), 64'd0);
        chk("hz_hilo", {bus.HI, bus.LO}, e);
        {m_hi, m_lo} = e;
        bus.ReadLo = 1'b0;
        tick();
        chk("hz_done_pulse", 64'(bus.Done), 64'd0);
        $display("[TB] hazard: stall cycles=%0d HI=%h LO=%h", stall_cnt, bus.HI, bus.LO);

        for (int i = 0; i < 8; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = (i == 5) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
            do_op({1'b0, rop}, ra, rb, (rop < 2) ? LAT : (W + 1), "rand");
        end

        do_op(OP_MTHI, 32'd0, 32'd0, 0, "madd_pre_hi");
        do_op(OP_MTLO, 32'hFFFF_FFFF, 32'd0, 0, "madd_pre_lo");
`ifdef HILO_MADD_EN
        do_op(OP_MADD, 32'd1, 32'd1, LAT, "madd");
        chk("madd_const", {bus.HI, bus.LO}, 64'h0000_0001_0000_0000);
        do_op(OP_MSUB, 32'd3, 32'hFFFF_FFFE, LAT, "msub");
`else
        bus.Op = OP_MADD; bus.A = 32'd1; bus.B = 32'd1; bus.Start = 1'b1;
        tick();
        bus.Start = 1'b0;
        watch_no_done(10, "madd_disabled");
        bus.Op = OP_MSUB; bus.Start = 1'b1;
        tick();
        bus.Start = 1'b0;
        watch_no_done(10, "msub_disabled");
`endif

        // Asynchronous reset in the middle of a divide.
        do_op(OP_MTHI, 32'h55, 32'd0, 0, "pre_reset_hi");
        bus.Op = OP_DIV; bus.A = 32'd77; bus.B = 32'd5; bus.Start = 1'b1;
        tick();
        bus.Start = 1'b0;
        repeat (10) tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_hilo", {bus.HI, bus.LO}, 64'd0);
        chk("midrst_busy", 64'(bus.Busy), 64'd0);
        chk("midrst_done", 64'(bus.Done), 64'd0);
        m_hi = '0;
        m_lo = '0;
        tick();
        rst_n = 1'b1;
        watch_no_done(40, "after_midrst");

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
